// File: rtl/key_event_pkg.sv
// Shared event encoding and input indexing for the key event queue and the synthesizer datapath.
package key_event_pkg;

  typedef enum logic [2:0] {
    EVT_INVALID = 3'h0,
    PRESS_KEY   = 3'h1,
    RELEASE_KEY = 3'h2,
    INCREASE    = 3'h3,
    DECREASE    = 3'h4,
    CHANGE_MENU = 3'h5
  } evt_type_e;

  localparam int unsigned NUM_INPUTS = 27;
  localparam int unsigned NUM_KEYS   = 24;
  localparam int unsigned IDX_INC    = 24;
  localparam int unsigned IDX_DEC    = 25;
  localparam int unsigned IDX_MENU   = 26;
  localparam int unsigned KEY_W      = 5;

  typedef struct packed {
    evt_type_e        evt_type;
    logic [KEY_W-1:0] key;
  } evt_t;

  // Button releases map to EVT_INVALID so the scanner skips them.
  function automatic evt_t encode_evt(input logic [KEY_W-1:0] idx, input logic level);
    evt_t e;
    e.evt_type = EVT_INVALID;
    e.key      = '0;
    if (32'(idx) < NUM_KEYS) begin
      e.evt_type = level ? PRESS_KEY : RELEASE_KEY;
      e.key      = idx;
    end else if (level) begin
      case (32'(idx))
        IDX_INC:  e.evt_type = INCREASE;
        IDX_DEC:  e.evt_type = DECREASE;
        IDX_MENU: e.evt_type = CHANGE_MENU;
        default:  e.evt_type = EVT_INVALID;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO; head reads as all-zero (EVT_INVALID) while empty.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output evt_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  evt_t          mem_q [DEPTH];
  evt_t          mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (empty) begin
      head = '0;
    end else begin
      head = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Debounces note keys and menu buttons, encodes edges as events and queues them for the datapath.
// Optional inc/dec auto-repeat is enabled by defining KEY_EVENT_AUTOREPEAT_EN.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV    = 125000,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned REPEAT_DELAY  = 200,
  parameter int unsigned REPEAT_PERIOD = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] keys,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_menu,
  input  logic        clear_evt,
  output logic [7:0]  evt,
  output logic [7:0]  evt_dropped
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  logic [NUM_INPUTS-1:0]      sync1_q, sync2_q;
  logic [NUM_INPUTS-1:0]      stable_q, stable_d;
  logic [NUM_INPUTS-1:0]      pending_q, pending_d;
  logic [NUM_INPUTS-1:0]      level_q, level_d;
  logic [NUM_INPUTS-1:0]      agree_c, chg_c, rep_c;
  logic [2:0][NUM_INPUTS-1:0] hist_q, hist_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic                       tick_c;
  state_e                     state_q, state_d;
  logic [KEY_W-1:0]           idx_q, idx_d;
  logic [7:0]                 dropped_q, dropped_d;
  evt_t                       scan_evt_c, head_c;
  logic                       push_c, full_c, empty_c, drop_c;

  // Sample tick prescaler.
  always_comb begin
    tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DIV_W'(1);
  end

  // A new stable value needs the current sample plus three history samples in agreement.
  always_comb begin
    agree_c   = ~(sync2_q ^ hist_q[0]) & ~(sync2_q ^ hist_q[1]) & ~(sync2_q ^ hist_q[2]);
    chg_c     = tick_c ? (agree_c & (sync2_q ^ stable_q)) : '0;
    stable_d  = stable_q ^ chg_c;
    hist_d    = tick_c ? {hist_q[1:0], sync2_q} : hist_q;
    pending_d = tick_c ? (chg_c | rep_c) : pending_q;
    level_d   = tick_c ? stable_d : level_q;
  end

`ifdef KEY_EVENT_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]            rep_on_q, rep_on_d;

  // Counters track held ticks since the press (delay phase) or since the last repeat (period phase).
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_on_d  = rep_on_q;
    rep_c     = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      if (tick_c) begin
        if (!stable_d[IDX_INC + b]) begin
          rep_cnt_d[b] = '0;
          rep_on_d[b]  = 1'b0;
        end else if (stable_q[IDX_INC + b]) begin
          if (rep_cnt_q[b] == (rep_on_q[b] ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY))) begin
            rep_c[IDX_INC + b] = 1'b1;
            rep_cnt_d[b]       = REP_W'(1);
            rep_on_d[b]        = 1'b1;
          end else begin
            rep_cnt_d[b] = rep_cnt_q[b] + REP_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_on_q  <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_on_q  <= rep_on_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep_c = '0;
`endif

  // Scanner: one input index per cycle, ascending, starting the cycle after a tick with edges.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_c && (pending_d != '0)) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q == KEY_W'(NUM_INPUTS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + KEY_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_evt_c = encode_evt(idx_q, level_q[idx_q]);
    push_c     = (state_q == ST_SCAN) && pending_q[idx_q] && (scan_evt_c.evt_type != EVT_INVALID);
    drop_c     = push_c && full_c && !clear_evt;
    dropped_d  = (drop_c && (dropped_q != 8'hFF)) ? dropped_q + 8'd1 : dropped_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      level_q   <= '0;
      div_q     <= '0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dropped_q <= '0;
    end else begin
      sync1_q   <= {btn_menu, btn_dec, btn_inc, keys};
      sync2_q   <= sync1_q;
      hist_q    <= hist_d;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      div_q     <= div_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

  key_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .push_data(scan_evt_c),
    .pop      (clear_evt),
    .full     (full_c),
    .empty    (empty_c),
    .head     (head_c)
  );

  assign evt         = head_c;
  assign evt_dropped = dropped_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: stimulus queues expected events, a negedge monitor pops and compares.
module tb_key_event_queue;

  localparam int unsigned SD    = 32;
  localparam int unsigned DEPTH = 8;
`ifdef KEY_EVENT_AUTOREPEAT_EN
  localparam int INC_N = 4;
  localparam int DEC_N = 2;
`else
  localparam int INC_N = 1;
  localparam int DEC_N = 1;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [23:0] keys      = '0;
  logic        btn_inc   = 1'b0;
  logic        btn_dec   = 1'b0;
  logic        btn_menu  = 1'b0;
  logic        clear_evt = 1'b0;
  logic [7:0]  evt;
  logic [7:0]  evt_dropped;

  int         checks      = 0;
  int         errors      = 0;
  int         cyc         = 0;
  bit         pop_en      = 1'b0;
  bit         force_clear = 1'b0;
  int         pop_on_drop = -1;
  logic [7:0] exp_q[$];
  int         pop_cyc_q[$];

  always #5 clk = ~clk;

  key_event_queue #(
    .SAMPLE_DIV   (SD),
    .FIFO_DEPTH   (DEPTH),
    .REPEAT_DELAY (3),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_menu   (btn_menu),
    .clear_evt  (clear_evt),
    .evt        (evt),
    .evt_dropped(evt_dropped)
  );

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops whenever popping is enabled and an event is presented.
  always @(negedge clk) begin
    logic [7:0] want;
    cyc = cyc + 1;
    if (pop_on_drop >= 0 && int'(evt_dropped) == pop_on_drop) begin
      pop_en      = 1'b1;
      pop_on_drop = -1;
    end
    if (pop_en && evt != 8'h00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got %02h with no event expected (cycle %0d)", evt, cyc);
      end else begin
        want = exp_q.pop_front();
        check8("evt_seq", evt, want);
      end
      pop_cyc_q.push_back(cyc);
      clear_evt = 1'b1;
    end else begin
      clear_evt = force_clear;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * int'(SD)) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 * int'(SD) && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_int({name, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check8("reset_evt", evt, 8'h00);
    check8("reset_dropped", evt_dropped, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check8("post_reset_evt", evt, 8'h00);

    // Pops while empty are ignored
    force_clear = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    force_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check8("empty_pop_evt", evt, 8'h00);
    check8("empty_pop_dropped", evt_dropped, 8'h00);

    // Single key press and release, both held in the FIFO
    exp_q.push_back(8'h25);
    exp_q.push_back(8'h45);
    keys[5] = 1'b1;
    wait_ticks(6);
    keys[5] = 1'b0;
    wait_ticks(6);
    check8("key5_head", evt, 8'h25);
    pop_en = 1'b1;
    wait_drain("key5");
    check8("key5_empty", evt, 8'h00);

    // Chatter: toggles every cycle, with a one-cycle hold per sample period so samples alternate
    for (int c = 0; c < 3 * int'(SD); c++) begin
      @(posedge clk);
      #1;
      if (c % int'(SD) != 0) keys[5] = ~keys[5];
    end
    keys[5] = 1'b0;
    wait_ticks(6);
    check8("chatter_evt", evt, 8'h00);
    check_int("chatter_queue", exp_q.size(), 0);

    // Two keys in the same tick: ascending order, enqueued four scan cycles apart
    pop_cyc_q.delete();
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h27);
    keys[3] = 1'b1;
    keys[7] = 1'b1;
    wait_ticks(6);
    wait_drain("pair_press");
    check_int("pair_pops", pop_cyc_q.size(), 2);
    if (pop_cyc_q.size() == 2) check_int("pair_spacing", pop_cyc_q[1] - pop_cyc_q[0], 4);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h47);
    keys[3] = 1'b0;
    keys[7] = 1'b0;
    wait_ticks(6);
    wait_drain("pair_release");

    // Ten presses without pops: eight queued, two dropped
    pop_en = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h20 | 8'(i));
    keys[9:0] = 10'h3FF;
    wait_ticks(6);
    check8("fill_dropped", evt_dropped, 8'd2);
    check8("fill_head", evt, 8'h20);
    // Release scan: key 0 hits a full FIFO and drops; popping then starts so later pushes meet a same-cycle pop
    for (int i = 1; i < 10; i++) exp_q.push_back(8'h40 | 8'(i));
    pop_on_drop = 3;
    keys[9:0] = 10'h000;
    wait_ticks(6);
    wait_drain("fill");
    check8("full_pop_dropped", evt_dropped, 8'd3);
    check8("fill_empty", evt, 8'h00);
    check_int("pop_trigger", int'(pop_en), 1);

    // Menu buttons; releases produce nothing
    for (int i = 0; i < INC_N; i++) exp_q.push_back(8'h60);
    btn_inc = 1'b1;
    wait_ticks(10);
    btn_inc = 1'b0;
    wait_ticks(6);
    wait_drain("inc");
    for (int i = 0; i < DEC_N; i++) exp_q.push_back(8'h80);
    btn_dec = 1'b1;
    wait_ticks(5);
    btn_dec = 1'b0;
    wait_ticks(6);
    wait_drain("dec");
    exp_q.push_back(8'hA0);
    btn_menu = 1'b1;
    wait_ticks(10);
    btn_menu = 1'b0;
    wait_ticks(6);
    wait_drain("menu");
    check8("final_evt", evt, 8'h00);
    check8("final_dropped", evt_dropped, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
